// File: rtl/alu_div_seq.sv
// Unsigned restoring divider: one trial subtract per clock, quotient/remainder built MSB first.
// Latency BITS+1 cycles (1 for divide-by-zero); new starts are ignored while busy, never queued.
module alu_div_seq #(
  parameter int BITS = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [BITS-1:0] o_quot,
  output logic [BITS-1:0] o_rem,
  output logic            o_div_zero
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [BITS-1:0] a_sh;
  logic [BITS-1:0] b_reg;
  logic [BITS-1:0] rem_acc;
  logic [BITS-2:0] quot_sh;
  logic [CW-1:0]   cnt;

  logic [BITS:0]   partial;
  logic [BITS:0]   diff;
  logic            borrow;
  logic [BITS-1:0] rem_nxt;
  logic [BITS-1:0] quot_nxt;
  logic            last_step;

  always_comb begin
    partial   = {rem_acc, a_sh[BITS-1]};
    diff      = partial - {1'b0, b_reg};
    borrow    = diff[BITS];
    // rem_acc < b holds throughout, so whichever value is kept fits in BITS bits
    rem_nxt   = borrow ? partial[BITS-1:0] : diff[BITS-1:0];
    quot_nxt  = {quot_sh, ~borrow};
    last_step = (cnt == CW'(BITS - 1));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (i_start) state_nxt = (i_b == '0) ? DONE : CALC;
      CALC: if (last_step) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_sh       <= '0;
      b_reg      <= '0;
      rem_acc    <= '0;
      quot_sh    <= '0;
      cnt        <= '0;
      o_quot     <= '0;
      o_rem      <= '0;
      o_div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_b == '0) begin
              o_quot     <= '1;
              o_rem      <= i_a;
              o_div_zero <= 1'b1;
            end else begin
              a_sh    <= i_a;
              b_reg   <= i_b;
              rem_acc <= '0;
              quot_sh <= '0;
              cnt     <= '0;
            end
          end
        end
        CALC: begin
          a_sh    <= a_sh << 1;
          rem_acc <= rem_nxt;
          quot_sh <= quot_nxt[BITS-2:0];
          cnt     <= cnt + 1'b1;
          // Results become visible only as DONE is entered
          if (last_step) begin
            o_quot     <= quot_nxt;
            o_rem      <= rem_nxt;
            o_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (state != IDLE);
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq: hand-computed quotient/remainder, latency, busy-ignore and reset cases.
module tb_alu_div_seq;

  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [BITS-1:0] a, b;
  logic            busy, done, dz;
  logic [BITS-1:0] quot, rem;

  int compares = 0;
  int fails    = 0;

  alu_div_seq #(.BITS(BITS)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_a        (a),
    .i_b        (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_quot     (quot),
    .o_rem      (rem),
    .o_div_zero (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one op, then counts cycles after the accept edge until o_done.
  task automatic run_op(input string tag, input logic [BITS-1:0] ta, input logic [BITS-1:0] tb_,
                        input int exp_lat, input logic [BITS-1:0] eq, input logic [BITS-1:0] er,
                        input logic edz);
    int n;
    a = ta; b = tb_; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_q"}, quot, eq);
    chk({tag, "_r"}, rem, er);
    chk({tag, "_dz"}, dz, edz);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quot, 0);
    chk("rst_r", rem, 0);
    chk("rst_dz", dz, 0);
    rst = 1'b0;
    tick();

    run_op("d10_5",   8'd10,  8'd5,   8, 8'd2,   8'd0,   1'b0);
    run_op("d8_10",   8'd8,   8'd10,  8, 8'd0,   8'd8,   1'b0);
    run_op("d15_8",   8'd15,  8'd8,   8, 8'd1,   8'd7,   1'b0);
    run_op("d254_252",8'd254, 8'd252, 8, 8'd1,   8'd2,   1'b0);
    run_op("d252_254",8'd252, 8'd254, 8, 8'd0,   8'd252, 1'b0);
    run_op("d254_254",8'd254, 8'd254, 8, 8'd1,   8'd0,   1'b0);
    run_op("d7_0",    8'd7,   8'd0,   0, 8'd255, 8'd7,   1'b1);

    // Outputs from the divide-by-zero must hold while the next op computes
    a = 8'd9; b = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("hold_q", quot, 255);
    chk("hold_dz", dz, 1);
    n = 3;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    chk("d9_3_lat", n, 8);
    chk("d9_3_q", quot, 3);
    chk("d9_3_r", rem, 0);
    chk("d9_3_dz", dz, 0);
    tick();

    // Start ignored while busy; operand changes after acceptance have no effect
    a = 8'd200; b = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    a = 8'd1; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0; a = 8'd0; b = 8'd0;
    n = 3;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    chk("ign_lat", n, 8);
    chk("ign_q", quot, 28);
    chk("ign_r", rem, 4);
    tick();
    chk("ign_not_queued", busy, 0);
    tick();
    chk("ign_still_idle", busy, 0);

    // Reset mid-operation clears everything at once and suppresses o_done
    a = 8'd255; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_q", quot, 0);
    chk("arst_r", rem, 0);
    chk("arst_dz", dz, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen++;
    end
    chk("arst_no_done", seen, 0);
    run_op("d255_1", 8'd255, 8'd1, 8, 8'd255, 8'd0, 1'b0);

    // Held start gives back-to-back ops every BITS+2 cycles
    a = 8'd100; b = 8'd9; start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 30) begin
      tick();
      n++;
    end
    chk("held_lat", n, 8);
    chk("held_q0", quot, 11);
    chk("held_r0", rem, 1);
    for (int k = 1; k <= 2; k++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!done && n < 30);
      chk($sformatf("held_period%0d", k), n, 10);
      chk($sformatf("held_q%0d", k), quot, 11);
      chk($sformatf("held_r%0d", k), rem, 1);
    end
    start = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule
